// File: rtl/player_keys_pkg.sv
// player_keys_pkg
//   Shared definitions for the PS/2 player key decoder:
//   - scan-code constants (prefixes, P1 arrows, P2 WASD, bomb keys)
//   - decoder FSM state enum
//   - key-index enum naming the ten tracked keys (index into the held-bit vector)
package player_keys_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // P1 arrow keys (only valid after an E0 prefix)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // P2 WASD keys (plain codes)
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Bomb keys: Space is plain, Right-Ctrl is E0 14
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;

  localparam int NUM_KEYS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  typedef enum logic [3:0] {
    KEY_P1_UP    = 4'd0,
    KEY_P1_DOWN  = 4'd1,
    KEY_P1_LEFT  = 4'd2,
    KEY_P1_RIGHT = 4'd3,
    KEY_P2_UP    = 4'd4,
    KEY_P2_DOWN  = 4'd5,
    KEY_P2_LEFT  = 4'd6,
    KEY_P2_RIGHT = 4'd7,
    KEY_P1_BOMB  = 4'd8,
    KEY_P2_BOMB  = 4'd9
  } key_idx_t;

endpackage

// File: rtl/key_code_lookup.sv
// key_code_lookup
//   Combinational scan-code table. Maps {extended, code} to a hit flag and
//   the index of the matching key. Extended and plain tables are disjoint,
//   so E0 75 and a bare 75 never resolve to the same key.
// Ports:
//   extended  in   1  code was preceded by an E0 prefix
//   code      in   8  scan-code byte
//   hit       out  1  code is one of the tracked keys
//   key_idx   out  4  key index (key_idx_t encoding), 0 when no hit
module key_code_lookup
  import player_keys_pkg::*;
(
  input  logic       extended,
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] key_idx
);

  always_comb begin
    hit     = 1'b0;
    key_idx = KEY_P1_UP;
    if (extended) begin
      case (code)
        SC_UP:    begin hit = 1'b1; key_idx = KEY_P1_UP;    end
        SC_DOWN:  begin hit = 1'b1; key_idx = KEY_P1_DOWN;  end
        SC_LEFT:  begin hit = 1'b1; key_idx = KEY_P1_LEFT;  end
        SC_RIGHT: begin hit = 1'b1; key_idx = KEY_P1_RIGHT; end
        SC_CTRL:  begin hit = 1'b1; key_idx = KEY_P1_BOMB;  end
        default:  ;
      endcase
    end else begin
      case (code)
        SC_W:     begin hit = 1'b1; key_idx = KEY_P2_UP;    end
        SC_S:     begin hit = 1'b1; key_idx = KEY_P2_DOWN;  end
        SC_A:     begin hit = 1'b1; key_idx = KEY_P2_LEFT;  end
        SC_D:     begin hit = 1'b1; key_idx = KEY_P2_RIGHT; end
        SC_SPACE: begin hit = 1'b1; key_idx = KEY_P2_BOMB;  end
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/player_key_decoder.sv
// player_key_decoder
//   Turns the PS/2 scan-code byte stream into held direction levels for both
//   players and one-cycle bomb pulses. A small FSM tracks the E0 (extended)
//   and F0 (break) prefixes; a held-bit vector remembers which keys are down.
// Parameters:
//   PREFIX_TIMEOUT  cycles a pending prefix may wait for its next byte
//                   (only used when KEY_PREFIX_TIMEOUT_EN is defined)
// Configuration macro:
//   KEY_PREFIX_TIMEOUT_EN  when defined, a pending prefix is abandoned after
//                          PREFIX_TIMEOUT idle cycles; otherwise it waits forever
// Ports:
//   clk                               in   1  system clock, rising edge
//   reset                             in   1  synchronous active-high reset
//   din                               in   8  scan-code byte
//   din_new                           in   1  strobe, din valid this cycle
//   p1_up/p1_down/p1_left/p1_right    out  1  P1 arrow keys held
//   p2_up/p2_down/p2_left/p2_right    out  1  P2 WASD keys held
//   p1_bomb                           out  1  one-cycle pulse on Right-Ctrl make
//   p2_bomb                           out  1  one-cycle pulse on Space make
module player_key_decoder
  import player_keys_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_new,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right,
  output logic       p1_bomb,
  output logic       p2_bomb
);

  dec_state_t           state_q, state_d;
  logic [NUM_KEYS-1:0]  held_q, held_d;
  logic                 p1_bomb_q, p1_bomb_d;
  logic                 p2_bomb_q, p2_bomb_d;

  logic                 lk_ext;
  logic                 lk_hit;
  logic [3:0]           lk_idx;
  logic                 set_key;
  logic                 clr_key;
  logic                 tmo_expired;

  // The byte after an E0 (make or break) is looked up in the extended table
  assign lk_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

  key_code_lookup u_lookup (
    .extended (lk_ext),
    .code     (din),
    .hit      (lk_hit),
    .key_idx  (lk_idx)
  );

`ifdef KEY_PREFIX_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(PREFIX_TIMEOUT - 1);

  logic [31:0] tmo_cnt;

  // Counts idle cycles while a prefix is pending; any byte restarts it
  always_ff @(posedge clk) begin
    if (reset || din_new || (state_q == ST_IDLE)) begin
      tmo_cnt <= '0;
    end else if (!tmo_expired) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_expired = (state_q != ST_IDLE) && !din_new && (tmo_cnt == TMO_LAST);
`else
  // Without the timeout build the parameter has no effect
  logic unused_prefix_timeout;
  assign unused_prefix_timeout = ^32'(PREFIX_TIMEOUT);
  assign tmo_expired = 1'b0;
`endif

  // State, held keys and registered bomb pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      held_q    <= '0;
      p1_bomb_q <= 1'b0;
      p2_bomb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      p1_bomb_q <= p1_bomb_d;
      p2_bomb_q <= p2_bomb_d;
    end
  end

  // Prefix tracking; decides whether the current byte is a make or a break
  always_comb begin
    state_d = state_q;
    set_key = 1'b0;
    clr_key = 1'b0;
    if (din_new) begin
      case (state_q)
        ST_IDLE: begin
          if (din == SC_EXT) begin
            state_d = ST_EXT;
          end else if (din == SC_BRK) begin
            state_d = ST_BRK;
          end else begin
            set_key = lk_hit;
          end
        end
        ST_EXT: begin
          if (din == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (din == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            set_key = lk_hit;
            state_d = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          clr_key = lk_hit;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_expired) begin
      state_d = ST_IDLE;
    end
  end

  // Held-bit update; a bomb pulses only on the first make while its bit is clear
  always_comb begin
    held_d    = held_q;
    p1_bomb_d = 1'b0;
    p2_bomb_d = 1'b0;
    if (set_key) begin
      if (!held_q[lk_idx]) begin
        p1_bomb_d = (lk_idx == KEY_P1_BOMB);
        p2_bomb_d = (lk_idx == KEY_P2_BOMB);
      end
      held_d[lk_idx] = 1'b1;
    end
    if (clr_key) begin
      held_d[lk_idx] = 1'b0;
    end
  end

  assign p1_up    = held_q[KEY_P1_UP];
  assign p1_down  = held_q[KEY_P1_DOWN];
  assign p1_left  = held_q[KEY_P1_LEFT];
  assign p1_right = held_q[KEY_P1_RIGHT];
  assign p2_up    = held_q[KEY_P2_UP];
  assign p2_down  = held_q[KEY_P2_DOWN];
  assign p2_left  = held_q[KEY_P2_LEFT];
  assign p2_right = held_q[KEY_P2_RIGHT];
  assign p1_bomb  = p1_bomb_q;
  assign p2_bomb  = p2_bomb_q;

endmodule

// File: tb/tb_player_key_decoder.sv
// tb_player_key_decoder
//   Directed bench for player_key_decoder. Outputs are packed as
//   {p1_up,p1_down,p1_left,p1_right,p2_up,p2_down,p2_left,p2_right,p1_bomb,p2_bomb}
//   and compared against hand-computed vectors, sampled on the falling edge.
//   The prefix-timeout scenario follows KEY_PREFIX_TIMEOUT_EN.
module tb_player_key_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_new;
  logic       p1_up, p1_down, p1_left, p1_right;
  logic       p2_up, p2_down, p2_left, p2_right;
  logic       p1_bomb, p2_bomb;

  int total;
  int bad;

  player_key_decoder #(.PREFIX_TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_new  (din_new),
    .p1_up    (p1_up),
    .p1_down  (p1_down),
    .p1_left  (p1_left),
    .p1_right (p1_right),
    .p2_up    (p2_up),
    .p2_down  (p2_down),
    .p2_left  (p2_left),
    .p2_right (p2_right),
    .p1_bomb  (p1_bomb),
    .p2_bomb  (p2_bomb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {p1_up, p1_down, p1_left, p1_right,
            p2_up, p2_down, p2_left, p2_right, p1_bomb, p2_bomb};
  endfunction

  // Called at a falling edge; returns at the next falling edge, after the
  // rising edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    din     = b;
    din_new = 1'b1;
    @(negedge clk);
    din_new = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din = 8'h00;
    din_new = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", outs(), 10'b0);
    end
  endtask

  task automatic test_wasd();
    send_byte(8'h1D);
    total++;
    if (outs() !== 10'b0000100000) begin
      bad++;
      $display("[TB] FAIL w_make got=%b want=%b", outs(), 10'b0000100000);
    end
    send_byte(8'hF0);
    total++;
    if (outs() !== 10'b0000100000) begin
      bad++;
      $display("[TB] FAIL w_after_f0 got=%b want=%b", outs(), 10'b0000100000);
    end
    send_byte(8'h1D);
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL w_break got=%b want=%b", outs(), 10'b0);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h1B);
    send_byte(8'h1C);
    send_byte(8'h23);
    total++;
    if (outs() !== 10'b0000011100) begin
      bad++;
      $display("[TB] FAIL sad_make got=%b want=%b", outs(), 10'b0000011100);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    total++;
    if (outs() !== 10'b0000010100) begin
      bad++;
      $display("[TB] FAIL a_break got=%b want=%b", outs(), 10'b0000010100);
    end
    send_byte(8'hF0);
    send_byte(8'h1B);
    send_byte(8'hF0);
    send_byte(8'h23);
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL sd_break got=%b want=%b", outs(), 10'b0);
    end
    // E1 / AA / FA are ignored; the FSM stays in IDLE so 1D still makes
    send_byte(8'hE1);
    send_byte(8'hAA);
    send_byte(8'hFA);
    send_byte(8'h1D);
    total++;
    if (outs() !== 10'b0000100000) begin
      bad++;
      $display("[TB] FAIL ignored_bytes got=%b want=%b", outs(), 10'b0000100000);
    end
    send_byte(8'hF0);
    send_byte(8'h1D);
  endtask

  task automatic test_extended();
    send_byte(8'hE0);
    send_byte(8'h75);
    total++;
    if (outs() !== 10'b1000000000) begin
      bad++;
      $display("[TB] FAIL up_make got=%b want=%b", outs(), 10'b1000000000);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL up_break got=%b want=%b", outs(), 10'b0);
    end
    send_byte(8'h75);
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL bare_75 got=%b want=%b", outs(), 10'b0);
    end
    // E0 1D is not in the extended table: must not set p2_up
    send_byte(8'hE0);
    send_byte(8'h1D);
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL ext_1d got=%b want=%b", outs(), 10'b0);
    end
  endtask

  task automatic test_opposite_dirs();
    send_byte(8'hE0);
    send_byte(8'h6B);
    send_byte(8'hE0);
    send_byte(8'h74);
    total++;
    if (outs() !== 10'b0011000000) begin
      bad++;
      $display("[TB] FAIL left_right got=%b want=%b", outs(), 10'b0011000000);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    total++;
    if (outs() !== 10'b0001000000) begin
      bad++;
      $display("[TB] FAIL left_release got=%b want=%b", outs(), 10'b0001000000);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
  endtask

  task automatic test_space_bomb();
    logic [9:0] seen [0:6];
    logic [9:0] want [0:6];
    want = '{10'b0000000001, 10'b0, 10'b0, 10'b0, 10'b0, 10'b0000000001, 10'b0};
    send_byte(8'h29); seen[0] = outs();
    send_byte(8'h29); seen[1] = outs();
    send_byte(8'h29); seen[2] = outs();
    idle(1);          seen[3] = outs();
    send_byte(8'hF0);
    send_byte(8'h29); seen[4] = outs();
    send_byte(8'h29); seen[5] = outs();
    idle(1);          seen[6] = outs();
    for (int i = 0; i < 7; i++) begin
      total++;
      if (seen[i] !== want[i]) begin
        bad++;
        $display("[TB] FAIL space_step%0d got=%b want=%b", i, seen[i], want[i]);
      end
    end
    send_byte(8'hF0);
    send_byte(8'h29);
  endtask

  task automatic test_ctrl_bomb();
    send_byte(8'hE0);
    send_byte(8'h14);
    total++;
    if (outs() !== 10'b0000000010) begin
      bad++;
      $display("[TB] FAIL ctrl_first got=%b want=%b", outs(), 10'b0000000010);
    end
    send_byte(8'hE0);
    send_byte(8'h14);
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL ctrl_repeat got=%b want=%b", outs(), 10'b0);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hE0);
    send_byte(8'h14);
    total++;
    if (outs() !== 10'b0000000010) begin
      bad++;
      $display("[TB] FAIL ctrl_again got=%b want=%b", outs(), 10'b0000000010);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h14);
  endtask

  task automatic test_reset_priority();
    din     = 8'h1C;
    din_new = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    din_new = 1'b0;
    idle(1);
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL reset_drops_byte got=%b want=%b", outs(), 10'b0);
    end
    send_byte(8'hE0);
    send_byte(8'hE0);
    send_byte(8'h72);
    total++;
    if (outs() !== 10'b0100000000) begin
      bad++;
      $display("[TB] FAIL e0_e0_72 got=%b want=%b", outs(), 10'b0100000000);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h72);
  endtask

  task automatic test_prefix_timeout();
    send_byte(8'hE0);
    idle(20);
    send_byte(8'h75);
`ifdef KEY_PREFIX_TIMEOUT_EN
    total++;
    if (outs() !== 10'b0) begin
      bad++;
      $display("[TB] FAIL timeout_75 got=%b want=%b", outs(), 10'b0);
    end
`else
    total++;
    if (outs() !== 10'b1000000000) begin
      bad++;
      $display("[TB] FAIL prefix_waits got=%b want=%b", outs(), 10'b1000000000);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
`endif
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    din     = 8'h00;
    din_new = 1'b0;
    @(negedge clk);
    test_reset();
    test_wasd();
    test_back_to_back();
    test_extended();
    test_opposite_dirs();
    test_space_bomb();
    test_ctrl_bomb();
    test_reset_priority();
    test_prefix_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
